// File: rtl/pwm_reg_bank.sv
// Register bank behind the SPI slave plus a two-channel PWM generator.
// Duty registers are shadowed and committed to the PWM core on period wrap.
module pwm_reg_bank #(
   parameter int          ADDR_REG_LEN = 3,
   parameter logic [7:0]  ID_VALUE     = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_REG_LEN-1:0] addr_reg,
   input  logic [7:0]              data_wr,
   input  logic                    wr_en,
   output logic [7:0]              data_rd,
   output logic [1:0]              pwm_out
);

   localparam logic [ADDR_REG_LEN-1:0] A_CTRL  = ADDR_REG_LEN'(0);
   localparam logic [ADDR_REG_LEN-1:0] A_PRE   = ADDR_REG_LEN'(1);
   localparam logic [ADDR_REG_LEN-1:0] A_PER   = ADDR_REG_LEN'(2);
   localparam logic [ADDR_REG_LEN-1:0] A_DUTY0 = ADDR_REG_LEN'(3);
   localparam logic [ADDR_REG_LEN-1:0] A_DUTY1 = ADDR_REG_LEN'(4);
   localparam logic [ADDR_REG_LEN-1:0] A_WRAPS = ADDR_REG_LEN'(5);
   localparam logic [ADDR_REG_LEN-1:0] A_SCR   = ADDR_REG_LEN'(6);
   localparam logic [ADDR_REG_LEN-1:0] A_ID    = ADDR_REG_LEN'(7);

   logic [2:0]      s_q, s_d;
   logic [3:0]      ctrl_q, ctrl_d;
   logic [7:0]      prescale_q, prescale_d;
   logic [7:0]      period_q, period_d;
   logic [1:0][7:0] duty_q, duty_d;
   logic [7:0]      wraps_q, wraps_d;
   logic [7:0]      scratch_q, scratch_d;
   logic [7:0]      pre_q, pre_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [1:0][7:0] act_q, act_d;
   logic [7:0]      data_rd_q, data_rd_d;
   logic [1:0]      pwm_q, pwm_d;

   logic wr_pulse;
   logic run;
   logic tick;
   logic wrap;

   always_comb begin
      s_d        = {s_q[1:0], wr_en};
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      period_d   = period_q;
      duty_d     = duty_q;
      wraps_d    = wraps_q;
      scratch_d  = scratch_q;
      pre_d      = pre_q;
      cnt_d      = cnt_q;
      act_d      = act_q;
      data_rd_d  = 8'h00;
      pwm_d      = 2'b00;

      // rising edge of the synchronized strobe; addr/data are quiet by then
      wr_pulse = s_q[1] & ~s_q[2];
      if (wr_pulse) begin
         case (addr_reg)
            A_CTRL:  ctrl_d     = data_wr[3:0];
            A_PRE:   prescale_d = data_wr;
            A_PER:   period_d   = data_wr;
            A_DUTY0: duty_d[0]  = data_wr;
            A_DUTY1: duty_d[1]  = data_wr;
            A_SCR:   scratch_d  = data_wr;
            default: ;
         endcase
      end

      case (addr_reg)
         A_CTRL:  data_rd_d = {4'h0, ctrl_q};
         A_PRE:   data_rd_d = prescale_q;
         A_PER:   data_rd_d = period_q;
         A_DUTY0: data_rd_d = duty_q[0];
         A_DUTY1: data_rd_d = duty_q[1];
         A_WRAPS: data_rd_d = wraps_q;
         A_SCR:   data_rd_d = scratch_q;
         A_ID:    data_rd_d = ID_VALUE;
         default: data_rd_d = 8'h00;
      endcase

      run  = |ctrl_q[1:0];
      tick = (pre_q == prescale_q);
      // a counter left above a shrunk PERIOD rolls through 255 -> 0
      wrap = tick & ((cnt_q == period_q) | (cnt_q == 8'hFF));

      if (run) begin
         pre_d = tick ? 8'h00 : pre_q + 8'd1;
         if (tick) begin
            cnt_d = wrap ? 8'h00 : cnt_q + 8'd1;
         end
         if (wrap) begin
            act_d   = duty_q;
            wraps_d = wraps_q + 8'd1;
         end
         for (int i = 0; i < 2; i++) begin
            pwm_d[i] = ctrl_q[i] & ((cnt_q < act_q[i]) ^ ctrl_q[i+2]);
         end
      end else begin
         pre_d = 8'h00;
         cnt_d = 8'h00;
         act_d = duty_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q        <= 3'b111;
         ctrl_q     <= 4'h0;
         prescale_q <= 8'h00;
         period_q   <= 8'hFF;
         duty_q     <= '0;
         wraps_q    <= 8'h00;
         scratch_q  <= 8'h00;
         pre_q      <= 8'h00;
         cnt_q      <= 8'h00;
         act_q      <= '0;
         data_rd_q  <= 8'h00;
         pwm_q      <= 2'b00;
      end else begin
         s_q        <= s_d;
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         period_q   <= period_d;
         duty_q     <= duty_d;
         wraps_q    <= wraps_d;
         scratch_q  <= scratch_d;
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         act_q      <= act_d;
         data_rd_q  <= data_rd_d;
         pwm_q      <= pwm_d;
      end
   end

   assign data_rd = data_rd_q;
   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_reg_bank.sv
// Scoreboard bench for pwm_reg_bank: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_pwm_reg_bank;

   localparam int K_RD    = 0;
   localparam int K_PWM   = 1;
   localparam int K_SNAP  = 2;
   localparam int K_DELTA = 3;
   localparam int K_TMO   = 4;

   typedef struct {
      int         kind;
      logic [7:0] exp;
      string      name;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] addr_reg;
   logic [7:0] data_wr;
   logic       wr_en;
   logic [7:0] data_rd;
   logic [1:0] pwm_out;

   item_t      sb_q[$];
   item_t      mon_it;
   logic       obs_v;
   logic [7:0] snap;
   logic [7:0] got;
   bit         cmp;
   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_tab [8];

   pwm_reg_bank #(.ADDR_REG_LEN(3), .ID_VALUE(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr_reg (addr_reg),
      .data_wr  (data_wr),
      .wr_en    (wr_en),
      .data_rd  (data_rd),
      .pwm_out  (pwm_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (obs_v) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: monitor strobed with no expectation");
         end else begin
            mon_it = sb_q.pop_front();
            cmp = 1'b1;
            got = 8'h00;
            case (mon_it.kind)
               K_RD:    got = data_rd;
               K_PWM:   got = {6'b0, pwm_out};
               K_DELTA: got = data_rd - snap;
               K_SNAP: begin
                  snap = data_rd;
                  cmp  = 1'b0;
               end
               default: begin
                  cmp = 1'b0;
                  total++;
                  bad++;
                  $display("FAIL %s: wait for pwm edge expired", mon_it.name);
               end
            endcase
            if (cmp) begin
               total++;
               if (got !== mon_it.exp) begin
                  bad++;
                  $display("FAIL %s: got %02h want %02h",
                           mon_it.name, got, mon_it.exp);
               end
            end
         end
      end
   end

   task automatic observe(input int kind, input logic [7:0] e,
                          input string n);
      item_t it;
      @(posedge clk);
      #1;
      it.kind = kind;
      it.exp  = e;
      it.name = n;
      sb_q.push_back(it);
      obs_v = 1'b1;
      @(negedge clk);
      #1;
      obs_v = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] e,
                     input string n);
      @(posedge clk);
      #1;
      addr_reg = a;
      observe(K_RD, e, n);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk);
      #1;
      addr_reg = a;
      data_wr  = d;
      wr_en    = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic sync_edge(input bit rise, input string n);
      logic prev;
      bit   hit;
      hit = 1'b0;
      @(negedge clk);
      prev = pwm_out[0];
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         if (pwm_out[0] == rise && prev != rise) hit = 1'b1;
         prev = pwm_out[0];
      end
      if (!hit) observe(K_TMO, 8'h00, n);
   endtask

   // k counts clks from the period start found by sync_edge
   task automatic check_seq(input int len, input int per, input int da,
                            input int db, input bit inv, input bit p1,
                            input string n, input bit drop_wr);
      int   d;
      logic e0;
      for (int k = 1; k <= len; k++) begin
         d  = (k < per) ? da : db;
         e0 = ((k % per) < d) ^ inv;
         if (drop_wr && k == 5) wr_en = 1'b0;
         observe(K_PWM, {6'b0, p1, e0}, n);
      end
   endtask

   task automatic wraps_delta(input int span, input logic [7:0] e,
                              input string n);
      @(posedge clk);
      #1;
      addr_reg = 3'd5;
      observe(K_SNAP, 8'h00, "snap");
      repeat (span - 1) @(posedge clk);
      observe(K_DELTA, e, n);
   endtask

   initial begin
      exp_tab = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      addr_reg = 3'd0;
      data_wr  = 8'h00;
      obs_v    = 1'b0;
      snap     = 8'h00;
      repeat (2) @(posedge clk);
      observe(K_RD, 8'h00, "rst_data_rd");
      observe(K_PWM, 8'h00, "rst_pwm");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int a = 0; a < 8; a++) rd(3'(a), exp_tab[a], "rst_map");

      wr(3'd6, 8'h3C);
      rd(3'd6, 8'h3C, "scratch_rw");
      wr(3'd7, 8'h12);
      rd(3'd7, 8'hA5, "id_ro");
      wr(3'd5, 8'h77);
      rd(3'd5, 8'h00, "wraps_ro");
      wr(3'd0, 8'hF0);
      rd(3'd0, 8'h00, "ctrl_hi_zero");

      // long strobe; data changes late so repeated writes would show
      @(posedge clk);
      #1;
      addr_reg = 3'd6;
      data_wr  = 8'h5A;
      wr_en    = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      data_wr = 8'h11;
      repeat (30) @(posedge clk);
      #1;
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
      rd(3'd6, 8'h5A, "held_one_write");

      @(posedge clk);
      #1;
      data_wr = 8'h77;
      wr_en   = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
      rd(3'd6, 8'h00, "wr_high_at_rst");
      wr(3'd6, 8'hC3);
      rd(3'd6, 8'hC3, "wr_after_rst");

      wr(3'd1, 8'd0);
      wr(3'd2, 8'd9);
      wr(3'd3, 8'd3);
      wr(3'd0, 8'h01);
      sync_edge(1'b1, "sync_basic");
      check_seq(20, 10, 3, 3, 1'b0, 1'b0, "pwm_basic", 1'b0);
      wraps_delta(10, 8'd1, "wraps_per10");

      sync_edge(1'b1, "sync_duty");
      addr_reg = 3'd3;
      data_wr  = 8'd7;
      wr_en    = 1'b1;
      check_seq(29, 10, 3, 7, 1'b0, 1'b0, "duty_shadow", 1'b1);

      wr(3'd0, 8'h05);
      sync_edge(1'b0, "sync_inv");
      check_seq(19, 10, 7, 7, 1'b1, 1'b0, "pwm_invert", 1'b0);

      wr(3'd0, 8'h03);
      wr(3'd3, 8'd3);
      sync_edge(1'b1, "sync_d1zero");
      check_seq(19, 10, 3, 3, 1'b0, 1'b0, "duty1_zero", 1'b0);
      wr(3'd4, 8'd10);
      sync_edge(1'b1, "sync_d1over");
      check_seq(19, 10, 3, 3, 1'b0, 1'b1, "duty1_over", 1'b0);

      wr(3'd0, 8'h01);
      wr(3'd3, 8'd1);
      wr(3'd2, 8'd0);
      repeat (300) @(posedge clk);
      for (int k = 0; k < 5; k++) observe(K_PWM, 8'h01, "period0_high");
      wraps_delta(10, 8'd10, "wraps_period0");

      wr(3'd3, 8'd3);
      wr(3'd1, 8'd3);
      wr(3'd2, 8'd9);
      sync_edge(1'b1, "sync_pre3");
      check_seq(79, 40, 12, 12, 1'b0, 1'b0, "prescale3", 1'b0);
      wraps_delta(40, 8'd1, "wraps_pre3");

      @(posedge clk);
      #1;
      addr_reg = 3'd2;
      rst_n    = 1'b0;
      observe(K_PWM, 8'h00, "rst_mid_pwm");
      observe(K_RD, 8'h00, "rst_mid_rd");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd(3'd5, 8'h00, "rst_wraps");
      rd(3'd2, 8'hFF, "rst_period");
      rd(3'd3, 8'h00, "rst_duty0");
      rd(3'd0, 8'h00, "rst_ctrl");
      for (int k = 0; k < 20; k++) observe(K_PWM, 8'h00, "post_rst_pwm");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
